// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg
//   Shared types and constants for the debug UART front end.
//   - rx_state_t / tx_state_t : receiver and transmitter FSM encodings
//   - DATA_BITS / STOP_BITS   : 8N1 frame shape
//   - DEFAULT_CLKS_PER_BIT    : 50 MHz / 115200 baud
package debug_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/debug_uart_tx.sv
// debug_uart_tx
//   8N1 transmitter with level-request arming. A byte is accepted from
//   data_send when start_trans is high in idle and the request has been
//   re-armed (start_trans seen low since the last accept), so a requester
//   holding start_trans high never causes a duplicate byte.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   data_send     : byte to send, captured on accept
//   start_trans   : level request
//   serial_out    : TX pad, idle high
//   byte_send     : one-cycle strobe at end of stop bit
//   tx_busy       : high from accept through the byte_send cycle
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_send,
    input  logic       start_trans,
    output logic       serial_out,
    output logic       byte_send,
    output logic       tx_busy
);

    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST    = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2:0]             bit_reg, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   armed_reg, armed_next;
    logic                   serial_reg, serial_next;
    logic                   busy_reg, busy_next;
    logic                   byte_send_reg, byte_send_next;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        armed_next     = armed_reg;
        serial_next    = serial_reg;
        busy_next      = busy_reg;
        byte_send_next = 1'b0;

        // Any low cycle on the request re-arms; accept below overrides.
        if (!start_trans) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            TX_IDLE: begin
                // busy drops one cycle after byte_send so it covers the strobe
                busy_next = 1'b0;
                if (start_trans && armed_reg) begin
                    shift_next  = data_send;
                    armed_next  = 1'b0;
                    busy_next   = 1'b1;
                    serial_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = TX_START;
                end
            end
            TX_START: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next    = '0;
                    bit_next    = '0;
                    serial_next = shift_reg[0];
                    state_next  = TX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (bit_reg == BIT_IDX_LAST) begin
                        serial_next = 1'b1;
                        state_next  = TX_STOP;
                    end else begin
                        bit_next    = bit_reg + 1'b1;
                        shift_next  = shift_reg >> 1;
                        serial_next = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_reg == STOP_LAST) begin
                    cnt_next       = '0;
                    byte_send_next = 1'b1;
                    state_next     = TX_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= TX_IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            armed_reg     <= 1'b1;
            serial_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            byte_send_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            armed_reg     <= armed_next;
            serial_reg    <= serial_next;
            busy_reg      <= busy_next;
            byte_send_reg <= byte_send_next;
        end
    end

    assign serial_out = serial_reg;
    assign byte_send  = byte_send_reg;
    assign tx_busy    = busy_reg;

endmodule

// File: rtl/debug_uart.sv
// debug_uart
//   Serial front end for the debug controller: 8N1 receiver (inline) and
//   transmitter (debug_uart_tx) sharing one bit-rate parameter.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   serial_in     : RX pad (asynchronous, idle high)
//   serial_out    : TX pad (idle high)
//   rx_data       : last good received byte
//   byte_rcv      : one-cycle strobe, rx_data updated
//   rx_frame_err  : one-cycle strobe, stop bit low, byte dropped
//   data_send     : byte to transmit
//   start_trans   : level transmit request
//   byte_send     : one-cycle strobe, byte fully sent
//   tx_busy       : transmitter busy
module debug_uart
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_in,
    output logic       serial_out,
    output logic [7:0] rx_data,
    output logic       byte_rcv,
    output logic       rx_frame_err,
    input  logic [7:0] data_send,
    input  logic       start_trans,
    output logic       byte_send,
    output logic       tx_busy
);

    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST    = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_IDX_LAST = 3'(DATA_BITS - 1);

    // Synchroniser and history reset low: after reset the line must be seen
    // high before a falling edge can register, so a reset in the middle of
    // a frame never produces a false start bit.
    logic                 sync1_reg, sync2_reg, hist_reg;
    logic                 rx_fall;

    rx_state_t            rx_state_reg, rx_state_next;
    logic [CNT_W-1:0]     rx_cnt_reg, rx_cnt_next;
    logic [2:0]           rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic [7:0]           rx_data_reg, rx_data_next;
    logic                 byte_rcv_reg, byte_rcv_next;
    logic                 frame_err_reg, frame_err_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            hist_reg  <= 1'b0;
        end else begin
            sync1_reg <= serial_in;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign rx_fall = hist_reg && !sync2_reg;

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_bit_next    = rx_bit_reg;
        rx_shift_next  = rx_shift_reg;
        rx_data_next   = rx_data_reg;
        byte_rcv_next  = 1'b0;
        frame_err_next = 1'b0;

        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Mid-bit check rejects short low glitches on the idle line.
                if (rx_cnt_reg == HALF_LAST) begin
                    if (sync2_reg) begin
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_cnt_next   = '0;
                        rx_bit_next   = '0;
                        rx_state_next = RX_DATA;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {sync2_reg, rx_shift_reg[DATA_BITS-1:1]};
                    if (rx_bit_reg == BIT_IDX_LAST) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == STOP_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_IDLE;
                    if (sync2_reg) begin
                        rx_data_next  = rx_shift_reg;
                        byte_rcv_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: begin
                rx_state_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg  <= RX_IDLE;
            rx_cnt_reg    <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            byte_rcv_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            rx_data_reg   <= rx_data_next;
            byte_rcv_reg  <= byte_rcv_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign rx_data      = rx_data_reg;
    assign byte_rcv     = byte_rcv_reg;
    assign rx_frame_err = frame_err_reg;

    debug_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_tx (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_send   (data_send),
        .start_trans (start_trans),
        .serial_out  (serial_out),
        .byte_send   (byte_send),
        .tx_busy     (tx_busy)
    );

endmodule

// File: tb/tb_debug_uart.sv
`timescale 1ns/1ps
module tb_debug_uart;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_in = 1'b1;
    logic       start_trans = 1'b0;
    logic [7:0] data_send = 8'h00;
    logic       serial_out;
    logic [7:0] rx_data;
    logic       byte_rcv;
    logic       rx_frame_err;
    logic       byte_send;
    logic       tx_busy;

    always #5 clk = ~clk;

    debug_uart #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .serial_out   (serial_out),
        .rx_data      (rx_data),
        .byte_rcv     (byte_rcv),
        .rx_frame_err (rx_frame_err),
        .data_send    (data_send),
        .start_trans  (start_trans),
        .byte_send    (byte_send),
        .tx_busy      (tx_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- scoreboards ----------------
    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] tx_q[$];

    int   rx_done_cyc = 0;
    int   acc_cyc     = 0;
    int   bs_cyc      = 0;
    int   bs_count    = 0;
    logic busy_prev   = 1'b0;
    logic b2b_check   = 1'b0;

    // RX monitor: every strobe must match the next expected event.
    rx_exp_t rx_e;
    always @(negedge clk) begin
        if (rst_n && (byte_rcv || rx_frame_err)) begin
            if (rx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got byte_rcv=%0b rx_frame_err=%0b rx_data=0x%02h required no event",
                         byte_rcv, rx_frame_err, rx_data);
            end else begin
                rx_e = rx_q.pop_front();
                check("rx_kind", {30'd0, byte_rcv, rx_frame_err}, rx_e.is_err ? 32'd1 : 32'd2);
                check("rx_data", {24'd0, rx_data}, {24'd0, rx_e.data});
                rx_done_cyc = cyc;
                $display("rx event: %s rx_data=0x%02h (expected 0x%02h) cycle %0d",
                         rx_e.is_err ? "frame_err" : "byte", rx_data, rx_e.data, cyc);
            end
        end
    end

    // TX strobe monitor: frame length, busy coverage of the strobe, b2b gap.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (tx_busy && !busy_prev) begin
                if (b2b_check) check_range("tx_b2b_gap", cyc - bs_cyc, 1, 2);
                acc_cyc = cyc;
            end
            if (byte_send) begin
                bs_count++;
                check("tx_busy_at_byte_send", {31'd0, tx_busy}, 32'd1);
                check("tx_frame_len", cyc - acc_cyc, 10 * CPB);
                bs_cyc = cyc;
            end
            busy_prev = tx_busy;
        end
    end

    task automatic wait_neg(input int n, inout logic ab);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // TX line decoder: samples serial_out mid-bit and checks against tx_q.
    initial begin : tx_dec
        logic [7:0] b;
        logic       ab;
        logic       st;
        logic       sp;
        forever begin
            @(negedge clk);
            if (rst_n && serial_out === 1'b0) begin
                ab = 1'b0;
                b  = 8'h00;
                wait_neg(4, ab);
                st = serial_out;
                for (int i = 0; i < 8; i++) begin
                    wait_neg(CPB, ab);
                    b[i] = serial_out;
                end
                wait_neg(CPB, ab);
                sp = serial_out;
                if (ab) begin
                    $display("tx frame aborted by reset");
                end else if (tx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got frame 0x%02h required no frame", b);
                end else begin
                    check("tx_start_bit", {31'd0, st}, 32'd0);
                    check("tx_stop_bit", {31'd0, sp}, 32'd1);
                    check("tx_byte", {24'd0, b}, {24'd0, tx_q[0]});
                    $display("tx frame: 0x%02h (expected 0x%02h) cycle %0d", b, tx_q[0], cyc);
                    void'(tx_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_rx(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = stop;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic wait_bs(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (byte_send) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: got no byte_send within 200 cycles required one", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_serial_out"}, {31'd0, serial_out}, 32'd1);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_byte_rcv"}, {31'd0, byte_rcv}, 32'd0);
        check({tag, "_rx_frame_err"}, {31'd0, rx_frame_err}, 32'd0);
        check({tag, "_byte_send"}, {31'd0, byte_send}, 32'd0);
        check({tag, "_tx_busy"}, {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin : main
        int t0;
        int bs0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // RX good byte 0xAE and its latency from the start edge
        rx_q.push_back({1'b0, 8'hAE});
        t0 = cyc;
        send_rx(8'hAE, 1'b1);
        repeat (6) @(negedge clk);
        check_range("rx_latency", rx_done_cyc - t0, 72, 84);

        // 2-cycle low glitch, then 0x85
        serial_in = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        repeat (20) @(negedge clk);
        rx_q.push_back({1'b0, 8'h85});
        send_rx(8'h85, 1'b1);
        repeat (12) @(negedge clk);

        // 0x55 with low stop bit: frame error, rx_data keeps 0x85
        rx_q.push_back({1'b1, 8'h85});
        send_rx(8'h55, 1'b0);
        repeat (12) @(negedge clk);
        check("rx_data_kept", {24'd0, rx_data}, 32'h85);

        // TX: hold request 100 cycles, one frame only; data change mid-frame ignored
        bs0 = bs_count;
        tx_q.push_back(8'h3C);
        data_send   = 8'h3C;
        start_trans = 1'b1;
        repeat (20) @(negedge clk);
        data_send = 8'hFF;
        repeat (80) @(negedge clk);
        start_trans = 1'b0;
        repeat (5) @(negedge clk);
        check("tx_hold_single", bs_count - bs0, 1);

        // TX back-to-back 0x12, 0x34
        bs0 = bs_count;
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        data_send   = 8'h12;
        start_trans = 1'b1;
        wait_bs("tx_b2b_first");
        b2b_check   = 1'b1;
        start_trans = 1'b0;
        @(negedge clk);
        data_send   = 8'h34;
        start_trans = 1'b1;
        wait_bs("tx_b2b_second");
        start_trans = 1'b0;
        b2b_check   = 1'b0;
        repeat (5) @(negedge clk);
        check("tx_b2b_count", bs_count - bs0, 2);

        // Reset in the middle of an RX data bit and a TX data bit
        fork
            send_rx(8'hC3, 1'b1);
            begin
                data_send   = 8'hA1;
                start_trans = 1'b1;
                repeat (30) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
                start_trans = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Recovery: full RX frame and TX request together
        bs0 = bs_count;
        rx_q.push_back({1'b0, 8'h5A});
        tx_q.push_back(8'h96);
        fork
            send_rx(8'h5A, 1'b1);
            begin
                data_send   = 8'h96;
                start_trans = 1'b1;
                wait_bs("tx_after_reset");
                start_trans = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("tx_after_reset_count", bs_count - bs0, 1);
        check("rx_queue_drained", rx_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout required test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
